// File: rtl/fp32_div_seq.sv
// Sequential FP32 divider: radix-2 restoring mantissa divide, round-to-nearest-even.
// Latency: 28 cycles for normal operands, 1 cycle for special cases.
// Backpressure: accepts only in IDLE; the result is held in DONE until out_ready.
module fp32_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
    state_t state, state_nxt;

    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [23:0]       mb_q;
    logic [24:0]       rem_q;
    logic [25:0]       quo_q;
    logic [4:0]        cnt_q;

    // Denormals are treated as zero: an exponent field of 0 means zero.
    logic [7:0] ea, eb;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in;
    assign ea      = a[30:23];
    assign eb      = b[30:23];
    assign a_zero  = (ea == 8'd0);
    assign b_zero  = (eb == 8'd0);
    assign a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
    assign a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
    assign sign_in = a[31] ^ b[31];

    logic        special;
    logic [31:0] spec_res;
    logic [3:0]  spec_flg;
    always_comb begin
        special  = 1'b1;
        spec_res = '0;
        spec_flg = '0;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = QNAN;
            spec_flg = 4'b1000;
        end else if (a_inf) begin
            spec_res = {sign_in, 8'hFF, 23'd0};
        end else if (b_inf) begin
            spec_res = {sign_in, 31'd0};
        end else if (b_zero) begin
            spec_res = {sign_in, 8'hFF, 23'd0};
            spec_flg = 4'b0100;
        end else if (a_zero) begin
            spec_res = {sign_in, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    // Pre-shifting the dividend keeps the quotient in [1,2), so bit 25 is always the integer bit.
    logic [23:0]       ma, mb;
    logic              ma_lt;
    logic [24:0]       rem_init;
    logic signed [9:0] exp_init;
    assign ma       = {1'b1, a[22:0]};
    assign mb       = {1'b1, b[22:0]};
    assign ma_lt    = (ma < mb);
    assign rem_init = ma_lt ? {ma, 1'b0} : {1'b0, ma};
    assign exp_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
                    - (ma_lt ? 10'sd1 : 10'sd0);

    logic        ge;
    logic [24:0] rem_sub;
    assign ge      = (rem_q >= {1'b0, mb_q});
    assign rem_sub = ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    logic [23:0]       mant;
    logic              guard, rnd, sticky, inc, carry;
    logic [22:0]       frac_r;
    logic signed [9:0] exp_r;
    logic [31:0]       round_res;
    logic [3:0]        round_flg;
    assign mant   = quo_q[25:2];
    assign guard  = quo_q[1];
    assign rnd    = quo_q[0];
    assign sticky = |rem_q;
    assign inc    = guard & (rnd | sticky | mant[0]);
    // An all-ones mantissa rounding up wraps the fraction to zero and bumps the exponent.
    assign carry  = inc & (&mant);
    assign frac_r = mant[22:0] + {22'd0, inc};
    assign exp_r  = exp_q + (carry ? 10'sd1 : 10'sd0);

    always_comb begin
        round_res = {sign_q, exp_r[7:0], frac_r};
        round_flg = 4'b0000;
        if (exp_r >= 10'sd255) begin
            round_res = {sign_q, 8'hFF, 23'd0};
            round_flg = 4'b0010;
        end else if (exp_r <= 10'sd0) begin
            round_res = {sign_q, 31'd0};
            round_flg = 4'b0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = special ? DONE : DIV;
            DIV:     if (cnt_q == 5'd25) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mb_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            result    <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_nxt == DONE);
            case (state)
                IDLE: if (in_valid) begin
                    sign_q <= sign_in;
                    exp_q  <= exp_init;
                    mb_q   <= mb;
                    rem_q  <= rem_init;
                    quo_q  <= '0;
                    cnt_q  <= '0;
                    if (special) begin
                        result <= spec_res;
                        flags  <= spec_flg;
                    end
                end
                DIV: begin
                    rem_q <= rem_sub << 1;
                    quo_q <= {quo_q[24:0], ge};
                    cnt_q <= cnt_q + 5'd1;
                end
                ROUND: begin
                    result <= round_res;
                    flags  <= round_flg;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_div_seq.sv
// Bench for fp32_div_seq: scoreboard of expected {result, flags}, per-scenario tasks.
module tb_fp32_div_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_pass = 0;
    logic [35:0] sb[$];

    fp32_div_seq dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .flags(flags), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic [35:0] exp_v);
        @(negedge clk);
        a = xa;
        b = xb;
        in_valid = 1'b1;
        sb.push_back(exp_v);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int edges, output bit to);
        edges = 0;
        to = 1'b0;
        while (!out_valid) begin
            if (edges >= 60) begin
                to = 1'b1;
                return;
            end
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic pop_exp(output logic [35:0] e);
        if (sb.size() == 0) e = 'x;
        else e = sb.pop_front();
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({in_ready, out_valid, result, flags} !== {1'b1, 1'b0, 32'h0, 4'h0})
            $display("FAIL reset_assert: got rdy=%b vld=%b res=%h flg=%b want 1 0 0 0",
                     in_ready, out_valid, result, flags);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, result, flags} !== {1'b1, 1'b0, 32'h0, 4'h0})
            $display("FAIL reset_release: got rdy=%b vld=%b res=%h flg=%b want 1 0 0 0",
                     in_ready, out_valid, result, flags);
        else n_pass++;
    endtask

    task automatic test_normal;
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [35:0] te [4];
        int ed;
        bit to;
        logic [35:0] e;
        ta = '{32'h40C00000, 32'h3F800000, 32'hC0E00000, 32'h3F800000};
        tb = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h3FC00000};
        te = '{{32'h40400000, 4'h0}, {32'h3EAAAAAB, 4'h0}, {32'hC0600000, 4'h0}, {32'h3F2AAAAB, 4'h0}};
        for (int i = 0; i < 4; i++) begin
            send(ta[i], tb[i], te[i]);
            wait_out(ed, to);
            n_checks++;
            if (to || ed != 27)
                $display("FAIL normal_latency[%0d]: got %0d edges (timeout=%0d) want 27", i, ed, to);
            else n_pass++;
            pop_exp(e);
            n_checks++;
            if ({result, flags} !== e)
                $display("FAIL normal_quot[%0d]: got %h/%b want %h/%b", i, result, flags, e[35:4], e[3:0]);
            else n_pass++;
            consume;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL normal_release[%0d]: got vld=%b rdy=%b want 0 1", i, out_valid, in_ready);
            else n_pass++;
        end
    endtask

    task automatic test_specials;
        logic [31:0] ta [9];
        logic [31:0] tb [9];
        logic [35:0] te [9];
        int ed;
        bit to;
        logic [35:0] e;
        ta = '{32'h3F800000, 32'h00000000, 32'hBF800000, 32'h7FC00001, 32'h7F800000,
               32'hFF800000, 32'h00000001, 32'h3F800000, 32'h80000000};
        tb = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F800000, 32'hFF800000,
               32'h40000000, 32'h3F800000, 32'h80000001, 32'h40400000};
        te = '{{32'h7F800000, 4'b0100}, {32'h7FC00000, 4'b1000}, {32'h80000000, 4'b0000},
               {32'h7FC00000, 4'b0000}, {32'h7FC00000, 4'b1000}, {32'hFF800000, 4'b0000},
               {32'h00000000, 4'b0000}, {32'hFF800000, 4'b0100}, {32'h80000000, 4'b0000}};
        for (int i = 0; i < 9; i++) begin
            send(ta[i], tb[i], te[i]);
            wait_out(ed, to);
            n_checks++;
            if (to || ed != 0)
                $display("FAIL special_latency[%0d]: got %0d edges (timeout=%0d) want 0", i, ed, to);
            else n_pass++;
            pop_exp(e);
            n_checks++;
            if ({result, flags} !== e)
                $display("FAIL special_res[%0d]: got %h/%b want %h/%b", i, result, flags, e[35:4], e[3:0]);
            else n_pass++;
            consume;
        end
    endtask

    task automatic test_ovf_unf;
        logic [31:0] ta [2];
        logic [31:0] tb [2];
        logic [35:0] te [2];
        int ed;
        bit to;
        logic [35:0] e;
        ta = '{32'h7F000000, 32'h00800000};
        tb = '{32'h3E800000, 32'h4B000000};
        te = '{{32'h7F800000, 4'b0010}, {32'h00000000, 4'b0001}};
        for (int i = 0; i < 2; i++) begin
            send(ta[i], tb[i], te[i]);
            wait_out(ed, to);
            n_checks++;
            if (to || ed != 27)
                $display("FAIL range_latency[%0d]: got %0d edges (timeout=%0d) want 27", i, ed, to);
            else n_pass++;
            pop_exp(e);
            n_checks++;
            if ({result, flags} !== e)
                $display("FAIL range_res[%0d]: got %h/%b want %h/%b", i, result, flags, e[35:4], e[3:0]);
            else n_pass++;
            consume;
        end
    endtask

    task automatic test_backpressure;
        int ed;
        bit to;
        bit seen;
        logic [35:0] e;
        send(32'h40C00000, 32'h40000000, {32'h40400000, 4'h0});
        @(negedge clk);
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40400000;
        in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_rdy_in_div: got %b want 0", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(ed, to);
        n_checks++;
        if (to) $display("FAIL bp_timeout: got no out_valid want out_valid");
        else n_pass++;
        pop_exp(e);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({result, flags} !== e || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL bp_hold[%0d]: got %h/%b vld=%b rdy=%b want %h/%b 1 0",
                         i, result, flags, out_valid, in_ready, e[35:4], e[3:0]);
            else n_pass++;
            @(negedge clk);
        end
        consume;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen || sb.size() != 0)
            $display("FAIL bp_ignored_input: got extra out_valid=%b queue=%0d want 0 0", seen, sb.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [35:0] te [3];
        int acc[$];
        int idx;
        int got;
        bit accepted;
        logic [35:0] e;
        ta = '{32'h40C00000, 32'h3F800000, 32'hC0E00000};
        tb = '{32'h40000000, 32'h40400000, 32'h40000000};
        te = '{{32'h40400000, 4'h0}, {32'h3EAAAAAB, 4'h0}, {32'hC0600000, 4'h0}};
        idx = 0;
        got = 0;
        out_ready = 1'b1;
        @(negedge clk);
        a = ta[0];
        b = tb[0];
        in_valid = 1'b1;
        for (int c = 0; c < 150 && got < 3; c++) begin
            if (out_valid) begin
                pop_exp(e);
                n_checks++;
                if ({result, flags} !== e)
                    $display("FAIL b2b_res[%0d]: got %h/%b want %h/%b", got, result, flags, e[35:4], e[3:0]);
                else n_pass++;
                got++;
            end
            accepted = 1'b0;
            if (in_valid && in_ready) begin
                sb.push_back(te[idx]);
                acc.push_back(c);
                accepted = 1'b1;
            end
            @(negedge clk);
            if (accepted) begin
                idx++;
                if (idx < 3) begin
                    a = ta[idx];
                    b = tb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        n_checks++;
        if (got != 3 || acc.size() != 3)
            $display("FAIL b2b_count: got %0d results %0d accepts want 3 3", got, acc.size());
        else n_pass++;
        for (int i = 1; i < acc.size(); i++) begin
            n_checks++;
            if (acc[i] - acc[i-1] != 29)
                $display("FAIL b2b_interval[%0d]: got %0d cycles want 29", i, acc[i] - acc[i-1]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int ed;
        bit to;
        bit seen;
        logic [35:0] e;
        send(32'h40C00000, 32'h40000000, {32'h40400000, 4'h0});
        for (int i = 0; i < 9; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, result, flags} !== {1'b1, 1'b0, 32'h0, 4'h0})
            $display("FAIL rst_mid: got rdy=%b vld=%b res=%h flg=%b want 1 0 0 0",
                     in_ready, out_valid, result, flags);
        else n_pass++;
        pop_exp(e);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen) $display("FAIL rst_mid_no_pulse: got out_valid pulse want none");
        else n_pass++;
        send(32'h40C00000, 32'h40000000, {32'h40400000, 4'h0});
        wait_out(ed, to);
        n_checks++;
        if (to || ed != 27)
            $display("FAIL rst_mid_latency: got %0d edges (timeout=%0d) want 27", ed, to);
        else n_pass++;
        pop_exp(e);
        n_checks++;
        if ({result, flags} !== e)
            $display("FAIL rst_mid_quot: got %h/%b want %h/%b", result, flags, e[35:4], e[3:0]);
        else n_pass++;
        consume;
    endtask

    initial begin
        test_reset;
        test_normal;
        test_specials;
        test_ovf_unf;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
